// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction-memory fetch controller placed directly upstream of
//            the IF stage. It converts a one-cycle fetch strobe plus the
//            current PC into a level req/ack transaction with a
//            variable-latency instruction memory. The fetched word is
//            delivered with a one-cycle valid pulse. A redirect flush discards
//            an in-flight fetch.
// Option   : IFETCH_TIMEOUT_EN - when defined, a wait counter aborts a
//            request that goes unacknowledged for too long. An abort from REQ
//            substitutes NOP_INSTR. fetch_err is set and stays set until rst.
// Ports    :
//   clk          in   system clock, rising-edge
//   rst          in   synchronous active-high reset
//   fetch_req    in   one-cycle fetch strobe from the stage sequencer
//   pc           in   fetch address, sampled when fetch_req is accepted
//   flush        in   branch/jump redirect, discards the in-flight fetch
//   imem_req     out  memory request level, held until ack/abort
//   imem_addr    out  registered fetch address
//   imem_ack     in   memory acknowledge (meaningful while imem_req=1)
//   imem_rdata   in   instruction word, valid with imem_ack
//   instr        out  last delivered instruction
//   instr_valid  out  one-cycle pulse, instr is new
//   busy         out  transaction in flight
//   stall        out  fetch_req ignored because busy (combinational)
//   fetch_err    out  sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 16,
    parameter int                TIMEOUT   = 15,
    parameter logic [DATA_W-1:0] NOP_INSTR = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              busy,
    output logic              stall,
    output logic              fetch_err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_REQ   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------------
    // Flops and their next-state values
    // ------------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    // Separate request flop (rather than a decode of state_q) keeps imem_req
    // and busy glitch-free registered outputs.
    logic              req_q,   req_d;

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [7:0] c_TO_LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       w_timeout;

    // Abort fires on the edge following the cycle in which the counter sits
    // at TIMEOUT-1, so imem_req is high for exactly TIMEOUT cycles.
    assign w_timeout = (state_q != c_ST_IDLE) && (cnt_q >= c_TO_LIMIT);

    // Wait counter: cleared on entry to REQ, carried across REQ->DRAIN,
    // incremented on every waiting cycle without ack, saturating at 255.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == c_ST_IDLE) begin
            if (fetch_req) begin
                cnt_d = 8'd0;
            end
        end else if (!imem_ack && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            c_ST_IDLE: begin
                // A flush in IDLE has nothing to discard, so a fetch_req in
                // the same cycle is still accepted.
                if (fetch_req) begin
                    addr_d  = pc;
                    state_d = c_ST_REQ;
                end
            end

            c_ST_REQ: begin
                if (imem_ack) begin
                    // Ack wins over any abort; a same-cycle flush drops data.
                    if (!flush) begin
                        instr_d = imem_rdata;
                        valid_d = 1'b1;
                    end
                    state_d = c_ST_IDLE;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (w_timeout) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = c_ST_IDLE;
                end
`endif
                else if (flush) begin
                    // The request cannot be withdrawn; wait for the
                    // memory to answer and throw the word away.
                    state_d = c_ST_DRAIN;
                end
            end

            c_ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = c_ST_IDLE;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = c_ST_IDLE;
                end
`endif
            end

            default: begin
                state_d = c_ST_IDLE;
            end
        endcase

        req_d = (state_d != c_ST_IDLE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            instr_q <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign busy        = req_q;
    assign stall       = fetch_req & req_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Self-checking bench for imem_fetch_ctrl. A per-cycle vector
//            table covers normal fetch, wait states, flushes and stray acks.
//            Hand-written sequences cover timeout / indefinite wait and
//            reset in the middle of a request. Delivered words are matched
//            against a queue of expected instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic [15:0] pc;
    logic        flush;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        busy;
    logic        stall;
    logic        fetch_err;

    imem_fetch_ctrl #(
        .ADDR_W    (16),
        .DATA_W    (16),
        .TIMEOUT   (15),
        .NOP_INSTR (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .pc          (pc),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .busy        (busy),
        .stall       (stall),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp_w;

    typedef struct {
        logic        fr;
        logic [15:0] pc;
        logic        fl;
        logic        ack;
        logic [15:0] rdata;
        logic        dlv;     // this row's rdata is expected to be delivered
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        e_busy;
        logic        e_stall;
    } vec_t;

    localparam int NV = 25;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic fr, input logic [15:0] p, input logic fl, input logic ack,
        input logic [15:0] rd, input logic dlv,
        input logic e_req, input logic [15:0] e_addr, input logic e_valid,
        input logic [15:0] e_instr, input logic e_busy, input logic e_stall);
        vec_t v;
        v.fr = fr; v.pc = p; v.fl = fl; v.ack = ack; v.rdata = rd; v.dlv = dlv;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_busy = e_busy; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic clear_inputs();
        fetch_req  = 1'b0;
        pc         = 16'h0000;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
    endtask

    // Scoreboard: every delivery must match the oldest expected word.
    always @(negedge clk) begin
        if (instr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: instr_valid with instr=%h, no delivery expected", instr);
            end else begin
                exp_w = exp_q.pop_front();
                if (instr !== exp_w) begin
                    failures++;
                    $display("FAIL sb_instr: got %h expected %h", instr, exp_w);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int req_cycles;

    initial begin
        //             fr  pc       fl ack rdata    dlv  req addr     vld instr    bsy stl
        // reset state, then fetch with ack on first request cycle
        vecs[0]  = mk(1, 16'h0010, 0, 0, 16'h0000, 0,   0, 16'h0000, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 16'h0000, 0, 1, 16'hA5C3, 1,   1, 16'h0010, 0, 16'h0000, 1, 0);
        vecs[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0010, 1, 16'hA5C3, 0, 0);
        // wait states with fetch_req re-asserted while busy
        vecs[3]  = mk(1, 16'h0040, 0, 0, 16'h0000, 0,   0, 16'h0010, 0, 16'hA5C3, 0, 0);
        vecs[4]  = mk(1, 16'h0099, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'hA5C3, 1, 1);
        vecs[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'hA5C3, 1, 0);
        vecs[6]  = mk(1, 16'h0077, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'hA5C3, 1, 1);
        vecs[7]  = mk(1, 16'h0088, 0, 0, 16'h0000, 0,   1, 16'h0040, 0, 16'hA5C3, 1, 1);
        vecs[8]  = mk(0, 16'h0000, 0, 1, 16'hBEEF, 1,   1, 16'h0040, 0, 16'hA5C3, 1, 0);
        vecs[9]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0040, 1, 16'hBEEF, 0, 0);
        vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0040, 0, 16'hBEEF, 0, 0);
        // flush mid-fetch, repeated flush in DRAIN, late ack discarded
        vecs[11] = mk(1, 16'h0050, 0, 0, 16'h0000, 0,   0, 16'h0040, 0, 16'hBEEF, 0, 0);
        vecs[12] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0050, 0, 16'hBEEF, 1, 0);
        vecs[13] = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0050, 0, 16'hBEEF, 1, 0);
        vecs[14] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   1, 16'h0050, 0, 16'hBEEF, 1, 0);
        vecs[15] = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0050, 0, 16'hBEEF, 1, 0);
        vecs[16] = mk(0, 16'h0000, 0, 1, 16'h1234, 0,   1, 16'h0050, 0, 16'hBEEF, 1, 0);
        vecs[17] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0050, 0, 16'hBEEF, 0, 0);
        // fetch accepted together with flush; flush+ack same cycle; refetch
        vecs[18] = mk(1, 16'h0060, 1, 0, 16'h0000, 0,   0, 16'h0050, 0, 16'hBEEF, 0, 0);
        vecs[19] = mk(0, 16'h0000, 1, 1, 16'hDEAD, 0,   1, 16'h0060, 0, 16'hBEEF, 1, 0);
        vecs[20] = mk(1, 16'h0020, 0, 0, 16'h0000, 0,   0, 16'h0060, 0, 16'hBEEF, 0, 0);
        vecs[21] = mk(0, 16'h0000, 0, 1, 16'hC0DE, 1,   1, 16'h0020, 0, 16'hBEEF, 1, 0);
        vecs[22] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0020, 1, 16'hC0DE, 0, 0);
        // stray ack while idle is ignored
        vecs[23] = mk(0, 16'h0000, 0, 1, 16'hFFFF, 0,   0, 16'h0020, 0, 16'hC0DE, 0, 0);
        vecs[24] = mk(0, 16'h0000, 0, 0, 16'h0000, 0,   0, 16'h0020, 0, 16'hC0DE, 0, 0);

        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- table-driven section ----------------
        for (int i = 0; i < NV; i++) begin
            fetch_req  = vecs[i].fr;
            pc         = vecs[i].pc;
            flush      = vecs[i].fl;
            imem_ack   = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            if (vecs[i].dlv) exp_q.push_back(vecs[i].rdata);
            @(negedge clk);
            chk("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
            chk("imem_addr",   i, 32'(imem_addr),   32'(vecs[i].e_addr));
            chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].e_valid));
            chk("instr",       i, 32'(instr),       32'(vecs[i].e_instr));
            chk("busy",        i, 32'(busy),        32'(vecs[i].e_busy));
            chk("stall",       i, 32'(stall),       32'(vecs[i].e_stall));
            chk("fetch_err",   i, 32'(fetch_err),   32'd0);
            @(posedge clk);
            #1;
        end
        clear_inputs();

        // ---------------- no-ack request: timeout or indefinite wait ----------------
        fetch_req = 1'b1;
        pc        = 16'h0070;
`ifdef IFETCH_TIMEOUT_EN
        exp_q.push_back(16'h0000);
`endif
        @(posedge clk);
        #1;
        fetch_req  = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (imem_req) req_cycles++;
            else break;
        end
`ifdef IFETCH_TIMEOUT_EN
        chk("timeout_req_cycles", 0, 32'(req_cycles), 32'd15);
        chk("timeout_valid",      0, 32'(instr_valid), 32'd1);
        chk("timeout_instr",      0, 32'(instr),       32'h0000);
        chk("timeout_err",        0, 32'(fetch_err),   32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("err_sticky",  k, 32'(fetch_err),   32'd1);
            chk("post_to_req", k, 32'(imem_req),    32'd0);
            chk("post_to_vld", k, 32'(instr_valid), 32'd0);
        end
        // start another request so reset hits a live transaction
        @(posedge clk);
        #1;
        fetch_req = 1'b1;
        pc        = 16'h0033;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(negedge clk);
        chk("pre_rst_req",  0, 32'(imem_req),  32'd1);
        chk("pre_rst_addr", 0, 32'(imem_addr), 32'h0033);
`else
        chk("wait_req_cycles", 0, 32'(req_cycles), 32'd100);
        chk("wait_err",        0, 32'(fetch_err),  32'd0);
        chk("wait_busy",       0, 32'(busy),       32'd1);
        chk("wait_addr",       0, 32'(imem_addr),  32'h0070);
`endif

        // ---------------- reset in REQ, late ack ignored ----------------
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5555;
        @(negedge clk);
        chk("rst_req",   0, 32'(imem_req),    32'd0);
        chk("rst_addr",  0, 32'(imem_addr),   32'h0000);
        chk("rst_instr", 0, 32'(instr),       32'h0000);
        chk("rst_valid", 0, 32'(instr_valid), 32'd0);
        chk("rst_busy",  0, 32'(busy),        32'd0);
        chk("rst_err",   0, 32'(fetch_err),   32'd0);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_valid", 0, 32'(instr_valid), 32'd0);
        chk("late_ack_instr", 0, 32'(instr),       32'h0000);
        chk("late_ack_busy",  0, 32'(busy),        32'd0);

        @(posedge clk);
        #1;
        chk("sb_leftover", 0, 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-memory fetch controller that sits directly upstream of the IF stage of the multi-cycle 16-bit RISC datapath. It turns the stage sequencer's one-cycle fetch request and the current PC into a req/ack transaction with a variable-latency instruction memory. It then delivers the fetched word to the fetch-decode buffer with a one-cycle valid pulse. It also handles redirect flushes of an in-flight fetch and, optionally, a memory-timeout recovery.

## Interface
- ADDR_W, 16, width of PC and instruction-memory address
- DATA_W, 16, instruction width
- TIMEOUT, 15, wait cycles after imem_req rises before abort (used only with IFETCH_TIMEOUT_EN; legal 2..255)
- NOP_INSTR, 16'h0000, word substituted on timeout
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset; synchronous, active-high
- fetch_req  in  1  one-cycle fetch strobe from the stage sequencer (IF enable)
- pc  in  ADDR_W  address to fetch; sampled only when a fetch_req is accepted
- flush  in  1  branch/jump redirect; discards the in-flight fetch
- imem_req  out  1  memory request; level, held until ack or abort
- imem_addr  out  ADDR_W  registered fetch address, stable while imem_req=1
- imem_ack  in  1  memory acknowledge; meaningful only while imem_req=1
- imem_rdata  in  DATA_W  instruction word, valid in the cycle imem_ack=1
- instr  out  DATA_W  last delivered instruction; held between deliveries
- instr_valid  out  1  one-cycle pulse; instr is new
- busy  out  1  transaction in flight (state != IDLE)
- stall  out  1  combinational fetch_req & busy (request ignored)
- fetch_err  out  1  sticky timeout flag; cleared only by rst

## Operation
- States: IDLE, REQ, DRAIN.
- IDLE: busy=0, imem_req=0.
  - fetch_req=1: latch pc into imem_addr, go to REQ.
  - flush in IDLE: no effect. fetch_req with flush in the same cycle is accepted.
- REQ: imem_req=1, imem_addr frozen.
  - imem_ack=1 and flush=0: capture imem_rdata into instr, pulse instr_valid, go to IDLE.
  - imem_ack=1 and flush=1 in the same cycle: data discarded, no pulse, go to IDLE.
  - flush=1 and imem_ack=0: go to DRAIN.
- DRAIN: imem_req stays 1, because a request is never withdrawn except on abort or rst.
  - imem_ack: discard data, go to IDLE.
  - Further flushes: ignored.
- fetch_req while busy: ignored, never queued. stall=1 that cycle.
- imem_ack while imem_req=0: ignored.
- instr is updated only on a non-flushed ack or on a timeout substitution.
- Wait counter: 8 bits, cleared on entry to REQ and kept (not cleared) on the REQ to DRAIN move. It increments each cycle in REQ/DRAIN without ack and saturates at 255.

## Timing
- Reset values: imem_req=0, imem_addr=0, instr=0, instr_valid=0, busy=0, fetch_err=0, state=IDLE, counter=0.
- rst mid-transaction: all of the above hold at the next edge. The outstanding memory request is abandoned.
- fetch_req sampled at edge N: imem_req=1 and imem_addr=pc from cycle N+1.
- imem_ack sampled at edge K: instr and instr_valid updated at K+1. imem_req=0 and state=IDLE at K+1.
- Minimum latency from fetch_req to instr_valid is 2 cycles, with ack in the first request cycle.
- A new fetch_req is accepted in the cycle instr_valid=1, because the state is already IDLE. Back-to-back throughput is one fetch per 2 cycles.
- stall is combinational. All other outputs are registered.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - In REQ or DRAIN, counter reaching TIMEOUT-1 with no ack aborts at the next edge.
  - On abort: imem_req=0, fetch_err=1, state=IDLE.
  - Abort from REQ also loads instr=NOP_INSTR and pulses instr_valid. Abort from DRAIN gives no pulse.
  - Ack in the abort cycle takes priority and completes normally.
- IFETCH_TIMEOUT_EN undefined:
  - The controller waits indefinitely for ack.
  - fetch_err is tied to 0 and the counter is not built.

## Test plan
- Reset then fetch: rst 2 cycles, pc=16'h0010, fetch_req, ack on first request cycle with rdata=16'hA5C3 -> imem_addr=16'h0010; instr=16'hA5C3 with instr_valid pulse 2 cycles after fetch_req; imem_req low after.
- Wait states: ack delayed 4 cycles, fetch_req re-asserted during wait -> stall=1 on each re-assertion, imem_addr unchanged, single instr_valid, second request ignored.
- Flush mid-fetch: flush 1 cycle after imem_req rises, ack 3 cycles later with rdata=16'h1234 -> imem_req held until ack, no instr_valid, instr keeps previous value, busy=0 after ack.
- Flush with ack in the same cycle -> no instr_valid. Next fetch_req with pc=16'h0020 -> imem_addr=16'h0020, normal delivery.
- Timeout (macro on, TIMEOUT=15): no ack -> imem_req drops after 15 request cycles, instr=16'h0000, instr_valid pulse, fetch_err=1 held until rst. Macro off: imem_req stays high for 100 cycles, fetch_err=0.
- rst asserted in REQ -> next cycle all outputs at reset values. A late ack is ignored with no instr_valid.
